ins_fetcher: RTL and testbench

Instruction fetch unit that sits directly upstream of the decoder. It holds the fetch PC and issues one-word requests to the instruction cache/memory controller. Returned words are buffered with their PC in a small circular queue and presented to the decoder under a stall-based handshake. Redirects from the decoder (jump/branch clear) and from the ROB (mispredict flush) empty the queue and restart fetch; a response already in flight when a redirect arrives is discarded.

---
 rtl/ins_fetcher_if.sv | 32 +++
 rtl/ins_fetcher.sv | 183 ++++++++++++++++++
 tb/tb_ins_fetcher.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/ins_fetcher_if.sv
// ins_fetcher_if: decoder-side and icache-side signals of the instruction fetch unit.
// The master modport is the fetch unit itself.
// The slave modport is its environment: the decoder, the ROB and the instruction cache.
interface ins_fetcher_if;
  // decoder side
  logic        ins_ready;
  logic [31:0] ins;
  logic [31:0] pc;
  logic        IFetcher_stall;
  logic        IFetcher_clear;
  logic [31:0] IFetcher_new_addr;
  // ROB flush
  logic        rob_clear;
  logic [31:0] rob_new_addr;
  // instruction cache / memory controller side
  logic        icache_req;
  logic [31:0] icache_addr;
  logic        icache_ready;
  logic [31:0] icache_data;

  modport master (
    output ins_ready, ins, pc, icache_req, icache_addr,
    input  IFetcher_stall, IFetcher_clear, IFetcher_new_addr,
    input  rob_clear, rob_new_addr, icache_ready, icache_data
  );

  modport slave (
    input  ins_ready, ins, pc, icache_req, icache_addr,
    output IFetcher_stall, IFetcher_clear, IFetcher_new_addr,
    output rob_clear, rob_new_addr, icache_ready, icache_data
  );
endinterface

// File: rtl/ins_fetcher.sv
// ins_fetcher: holds the fetch PC and issues one-word icache requests.
// Returned words are buffered together with their PC in a circular queue.
// The queue is presented to the decoder under a stall handshake.
// Decoder clears and ROB flushes empty the queue and restart fetch.
// A response still in flight when a redirect arrives is discarded.
// Optional feature macro: IFQ_BYPASS_EN.
//   When defined, a word arriving while the queue is empty is shown to the decoder
//   in the same cycle; if the decoder takes it, the word is never enqueued.
module ins_fetcher #(
  parameter int          QUEUE_DEPTH_BIT = 2,
  parameter logic [31:0] RESET_PC        = 32'h0
) (
  input  logic          clk_in,
  input  logic          rst_in,
  input  logic          rdy_in,
  ins_fetcher_if.master fetch_bus
);
  localparam int DEPTH = 1 << QUEUE_DEPTH_BIT;
  localparam logic [QUEUE_DEPTH_BIT:0] DEPTH_CNT = DEPTH[QUEUE_DEPTH_BIT:0];

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_DISCARD = 2'd2
  } state_t;

  state_t                     r_state;
  logic [31:0]                r_fpc;
  logic                       r_icache_req;
  logic [31:0]                r_icache_addr;
  logic [QUEUE_DEPTH_BIT-1:0] r_head;
  logic [QUEUE_DEPTH_BIT-1:0] r_tail;
  logic [QUEUE_DEPTH_BIT:0]   r_count;
  logic [31:0]                r_q_pc  [DEPTH];
  logic [31:0]                r_q_ins [DEPTH];

  state_t                     w_state_next;
  logic [31:0]                w_fpc_next;
  logic                       w_req_next;
  logic [31:0]                w_addr_next;
  logic                       w_redirect;
  logic [31:0]                w_target;
  logic                       w_q_valid;
  logic                       w_rsp;
  logic                       w_byp;
  logic                       w_pop;
  logic                       w_enq;
  logic [DEPTH-1:0]           w_we;

  // The ROB flush outranks a decoder clear that arrives in the same cycle.
  assign w_redirect = fetch_bus.rob_clear | fetch_bus.IFetcher_clear;
  assign w_target   = fetch_bus.rob_clear ? fetch_bus.rob_new_addr : fetch_bus.IFetcher_new_addr;

  assign w_q_valid = (r_count != '0);
  // A response for the live request.
  // A response that arrives in DISCARD is never counted here.
  assign w_rsp     = (r_state == ST_REQ) & fetch_bus.icache_ready;

`ifdef IFQ_BYPASS_EN
  assign w_byp = ~w_q_valid & w_rsp & ~w_redirect & rdy_in;
`else
  assign w_byp = 1'b0;
`endif

  // The head only leaves the queue when the fetch unit is running.
  assign w_pop = w_q_valid & ~fetch_bus.IFetcher_stall & rdy_in;
  // A bypassed word that the decoder accepted does not also go into the queue.
  assign w_enq = w_rsp & ~w_redirect & ~(w_byp & ~fetch_bus.IFetcher_stall);

  assign fetch_bus.ins_ready   = w_q_valid | w_byp;
  assign fetch_bus.ins         = w_byp ? fetch_bus.icache_data : r_q_ins[r_head];
  assign fetch_bus.pc          = w_byp ? r_icache_addr         : r_q_pc[r_head];
  assign fetch_bus.icache_req  = r_icache_req;
  assign fetch_bus.icache_addr = r_icache_addr;

  // Per-entry write enables decoded from the tail pointer.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_we
      assign w_we[gi] = w_enq & (r_tail == QUEUE_DEPTH_BIT'(gi));
    end
  endgenerate

  // Next-state logic for the fetch FSM: compute the request, the address and the fetch PC.
  always_comb begin
    w_state_next = r_state;
    w_fpc_next   = r_fpc;
    w_req_next   = r_icache_req;
    w_addr_next  = r_icache_addr;
    case (r_state)
      ST_IDLE: begin
        if (w_redirect) begin
          w_fpc_next = w_target;
        end else if (r_count < DEPTH_CNT) begin
          w_addr_next  = r_fpc;
          w_req_next   = 1'b1;
          w_state_next = ST_REQ;
        end
      end
      ST_REQ: begin
        if (fetch_bus.icache_ready) begin
          w_req_next   = 1'b0;
          w_state_next = ST_IDLE;
          w_fpc_next   = w_redirect ? w_target : (r_fpc + 32'd4);
        end else if (w_redirect) begin
          // The old request stays on the bus until it completes; its data will be dropped.
          w_fpc_next   = w_target;
          w_state_next = ST_DISCARD;
        end
      end
      ST_DISCARD: begin
        if (w_redirect) begin
          w_fpc_next = w_target;
        end
        if (fetch_bus.icache_ready) begin
          w_req_next   = 1'b0;
          w_state_next = ST_IDLE;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
        w_req_next   = 1'b0;
      end
    endcase
  end

  // FSM state, fetch PC and the registered request outputs; all of them are frozen while paused.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_state       <= ST_IDLE;
      r_fpc         <= RESET_PC;
      r_icache_req  <= 1'b0;
      r_icache_addr <= RESET_PC;
    end else if (rdy_in) begin
      r_state       <= w_state_next;
      r_fpc         <= w_fpc_next;
      r_icache_req  <= w_req_next;
      r_icache_addr <= w_addr_next;
    end
  end

  // Queue pointers and occupancy; a redirect empties the queue even if the head was consumed.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (rdy_in) begin
      if (w_redirect) begin
        r_count <= '0;
        r_head  <= r_tail;
      end else begin
        if (w_enq) begin
          r_tail <= r_tail + 1'b1;
        end
        if (w_pop) begin
          r_head <= r_head + 1'b1;
        end
        case ({w_enq, w_pop})
          2'b10:   r_count <= r_count + 1'b1;
          2'b01:   r_count <= r_count - 1'b1;
          default: r_count <= r_count;
        endcase
      end
    end
  end

  // Queue storage: each entry holds a {pc, ins} pair, written at the tail slot.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_q_pc[i]  <= '0;
        r_q_ins[i] <= '0;
      end
    end else if (rdy_in) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (w_we[i]) begin
          r_q_pc[i]  <= r_icache_addr;
          r_q_ins[i] <= fetch_bus.icache_data;
        end
      end
    end
  end
endmodule

// File: tb/tb_ins_fetcher.sv
// tb_ins_fetcher: scoreboard bench for ins_fetcher.
// The reference model is the architectural instruction stream:
// - starting at RESET_PC, the decoder must see PC, PC+4, ... with ins = mem_word(pc);
// - a redirect restarts the stream at the target, with the ROB target winning when both fire.
// The driver pushes the expected stream into a queue.
// The negedge monitor pops one entry per accepted word.
module tb_ins_fetcher;
  localparam logic [31:0] RST_PC = 32'h0;
`ifdef IFQ_BYPASS_EN
  localparam logic BYP = 1'b1;
`else
  localparam logic BYP = 1'b0;
`endif

  logic clk_in;
  logic rst_in = 1'b1;
  logic rdy_in;
  ins_fetcher_if bus ();

  ins_fetcher #(.QUEUE_DEPTH_BIT(2), .RESET_PC(RST_PC)) dut (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .rdy_in   (rdy_in),
    .fetch_bus(bus)
  );

  initial begin
    clk_in = 1'b0;
    forever #5 clk_in = ~clk_in;
  end

  int n_checks = 0;
  int n_errors = 0;
  int n_pops   = 0;
  int n_pulses = 0;

  logic [63:0] exp_q[$];
  logic [31:0] exp_pc;

  // stimulus knobs (percent probabilities, latency range)
  int p_pause = 0, p_stall = 0, p_redir = 0, lat_min = 2, lat_max = 2;
  bit phase_lat = 0, lat_next = 0, expect_empty = 0;
  logic [31:0] p1_addr;

  // memory model state
  bit mem_busy = 0;
  int mem_cnt = 0;
  logic [31:0] mem_addr;

  bit pend_redir = 0;
  logic [31:0] pend_tgt;
  bit prev_paused = 0;
  logic prev_req;
  logic [31:0] prev_addr;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
  endfunction

  function automatic logic [31:0] rand_tgt();
    logic [31:0] r;
    r = $urandom;
    if (r[3:0] == 4'd0) return 32'hFFFF_FFF8;
    return {20'h0, r[11:2], 2'b00};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic restart_stream(input logic [31:0] start);
    exp_q.delete();
    exp_pc = start;
  endtask

  task automatic top_up();
    while (exp_q.size() < 16) begin
      exp_q.push_back({exp_pc, mem_word(exp_pc)});
      exp_pc = exp_pc + 32'd4;
    end
  endtask

  task automatic do_reset();
    bus.IFetcher_clear = 1'b0;
    bus.rob_clear      = 1'b0;
    bus.icache_ready   = 1'b0;
    rst_in = 1'b0;
    #1;
    check("rst_icache_req",  {63'd0, bus.icache_req}, 64'd0);
    check("rst_ins_ready",   {63'd0, bus.ins_ready},  64'd0);
    check("rst_ins",         {32'd0, bus.ins},        64'd0);
    check("rst_pc",          {32'd0, bus.pc},         64'd0);
    check("rst_icache_addr", {32'd0, bus.icache_addr}, {32'd0, RST_PC});
    repeat (2) @(posedge clk_in);
    @(negedge clk_in);
    rst_in      = 1'b1;
    mem_busy    = 0;
    pend_redir  = 0;
    prev_paused = 0;
    expect_empty = 0;
    restart_stream(RST_PC);
    top_up();
  endtask

  // One clock cycle of stimulus: apply last cycle's redirect to the model,
  // then drive the decoder, ROB and memory inputs for this cycle.
  task automatic step();
    int lat;
    int sel;
    @(posedge clk_in);
    #1;
    if (pend_redir) begin
      restart_stream(pend_tgt);
      pend_redir   = 0;
      expect_empty = 1;
    end
    top_up();
    if (prev_paused) begin
      check("pause_hold_req",  {63'd0, bus.icache_req},  {63'd0, prev_req});
      check("pause_hold_addr", {32'd0, bus.icache_addr}, {32'd0, prev_addr});
    end
    bus.icache_ready      = 1'b0;
    bus.IFetcher_clear    = 1'b0;
    bus.rob_clear         = 1'b0;
    bus.IFetcher_new_addr = $urandom;
    bus.rob_new_addr      = $urandom;
    bus.icache_data       = $urandom;
    rdy_in             = ($urandom_range(99, 0) >= p_pause);
    bus.IFetcher_stall = ($urandom_range(99, 0) < p_stall);
    // memory: answer each request once, after a random latency, only while running
    if (!bus.icache_req) begin
      mem_busy = 0;
    end else begin
      if (!mem_busy) begin
        lat = $urandom_range(lat_max, lat_min);
        mem_busy = 1;
        mem_addr = bus.icache_addr;
        mem_cnt  = lat;
        if (phase_lat) begin
          check("req_addr_seq", {32'd0, bus.icache_addr}, {32'd0, p1_addr});
          p1_addr = p1_addr + 32'd4;
        end
      end else begin
        check("req_addr_stable", {32'd0, bus.icache_addr}, {32'd0, mem_addr});
      end
      if (rdy_in) begin
        if (mem_cnt == 0) begin
          bus.icache_ready = 1'b1;
          bus.icache_data  = mem_word(mem_addr);
          mem_busy = 0;
          n_pulses++;
        end else begin
          mem_cnt--;
        end
      end
    end
    if (rdy_in && ($urandom_range(99, 0) < p_redir)) begin
      sel = $urandom_range(2, 0);
      bus.IFetcher_new_addr = rand_tgt();
      bus.rob_new_addr      = rand_tgt();
      bus.IFetcher_clear    = (sel != 1);
      bus.rob_clear         = (sel != 0);
      pend_tgt   = (sel != 0) ? bus.rob_new_addr : bus.IFetcher_new_addr;
      pend_redir = 1;
      $display("redirect rob=%0d dec=%0d target=%h", bus.rob_clear, bus.IFetcher_clear, pend_tgt);
    end
    prev_paused = !rdy_in;
    prev_req    = bus.icache_req;
    prev_addr   = bus.icache_addr;
  endtask

  // Monitor: compare every word the decoder accepts against the expected stream.
  always @(negedge clk_in) begin
    logic [63:0] e;
    if (rst_in) begin
      if (expect_empty) begin
        check("empty_after_redirect", {63'd0, bus.ins_ready}, 64'd0);
        expect_empty = 0;
      end
      if (phase_lat) begin
        if (bus.icache_ready) begin
          check("ready_same_cycle", {63'd0, bus.ins_ready}, {63'd0, BYP});
          lat_next = 1;
        end else if (lat_next) begin
          check("ready_next_cycle", {63'd0, bus.ins_ready}, {63'd0, ~BYP});
          lat_next = 0;
        end
      end
      if (bus.ins_ready && !bus.IFetcher_stall && rdy_in) begin
        n_pops++;
        if (exp_q.size() == 0) begin
          check("pop_scoreboard_nonempty", 64'd0, 64'd1);
        end else begin
          e = exp_q.pop_front();
          check("pop_word", {bus.pc, bus.ins}, e);
          $display("pop pc=%h ins=%h", bus.pc, bus.ins);
        end
      end
    end
  end

  initial begin
    int base;
    bit seen;
    rdy_in = 1'b1;
    bus.IFetcher_stall    = 1'b0;
    bus.IFetcher_clear    = 1'b0;
    bus.IFetcher_new_addr = '0;
    bus.rob_clear         = 1'b0;
    bus.rob_new_addr      = '0;
    bus.icache_ready      = 1'b0;
    bus.icache_data       = '0;
    #2;
    do_reset();

    // sequential fetch, fixed 2-cycle latency, decoder always ready
    phase_lat = 1;
    p1_addr   = RST_PC;
    repeat (30) step();
    phase_lat = 0;
    lat_next  = 0;

    // stalled decoder: exactly four words fill the queue, then fetching stops
    do_reset();
    p_stall = 100; lat_min = 0; lat_max = 3;
    base = n_pulses;
    repeat (40) step();
    check("stall_fill_count", 64'(n_pulses - base), 64'd4);
    check("stall_no_req",     {63'd0, bus.icache_req}, 64'd0);
    p_stall = 0;
    base = n_pops;
    repeat (10) step();
    check("stall_release_pops", 64'(n_pops - base >= 4), 64'd1);

    // randomized traffic with pauses, stalls and redirects; one reset mid-request
    p_pause = 10; p_stall = 30; p_redir = 4;
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) begin
        seen = 0;
        for (int k = 0; k < 50 && !seen; k++) begin
          step();
          seen = bus.icache_req;
        end
        check("req_before_reset", {63'd0, seen}, 64'd1);
        do_reset();
      end
      step();
    end

    // drain: the stream must keep flowing once the decoder is free
    p_pause = 0; p_stall = 0; p_redir = 0;
    base = n_pops;
    repeat (40) step();
    check("drain_progress", 64'(n_pops - base >= 5), 64'd1);

    @(posedge clk_in);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
